// File: rtl/rs_param_pkg.sv
// Shared defaults, ALU opcode encodings and the reservation-station entry record.
package rs_param_pkg;

  localparam int unsigned RS_DEPTH = 16;
  localparam int unsigned RS_XLEN  = 32;
  localparam int unsigned RS_TAG_W = 4;
  localparam int unsigned RS_OP_W  = 6;

  typedef enum logic [RS_OP_W-1:0] {
    ALU_ADD = 6'h00,
    ALU_SUB = 6'h01,
    ALU_AND = 6'h02,
    ALU_OR  = 6'h03,
    ALU_XOR = 6'h04,
    ALU_SLL = 6'h05,
    ALU_SRL = 6'h06,
    ALU_SLT = 6'h07
  } alu_op_e;

  // Entry record at the default widths; an operand payload holds the
  // producer tag in its low bits until the operand becomes ready.
  typedef struct packed {
    logic                valid;
    logic [RS_OP_W-1:0]  op;
    logic [RS_TAG_W-1:0] tag;
    logic                q1_rdy;
    logic [RS_XLEN-1:0]  v1;
    logic                q2_rdy;
    logic [RS_XLEN-1:0]  v2;
  } rs_entry_t;

endpackage

// File: rtl/rs_param_select.sv
// Oldest-ready picker: grants the requesting entry that no other requester is older than.
module rs_select
  import rs_param_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH
) (
  input  logic [DEPTH-1:0]            i_req,
  input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
  output logic [DEPTH-1:0]            o_gnt,
  output logic                        o_any
);

  // i_age[j][i] set means entry j was dispatched before entry i
  always_comb begin
    o_gnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_gnt[i] = i_req[i];
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j != i && i_req[j] && i_age[j][i]) o_gnt[i] = 1'b0;
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/rs_param.sv
// Parameterised reservation station: dispatch, CDB wakeup/bypass, age-ordered issue.
module rs_param
  import rs_param_pkg::*;
#(
  parameter int unsigned DEPTH   = RS_DEPTH,
  parameter int unsigned XLEN    = RS_XLEN,
  parameter int unsigned TAG_W   = RS_TAG_W,
  parameter int unsigned OP_W    = RS_OP_W,
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       disp_valid,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [TAG_W-1:0]           disp_tag,
  input  logic                       disp_q1_rdy,
  input  logic [XLEN-1:0]            disp_v1,
  input  logic                       disp_q2_rdy,
  input  logic [XLEN-1:0]            disp_v2,
  output logic                       disp_ready,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_val,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [XLEN-1:0]            iss_v1,
  output logic [XLEN-1:0]            iss_v2,
  output logic [TAG_W-1:0]           iss_tag,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tag;
    logic             q1_rdy;
    logic [XLEN-1:0]  v1;
    logic             q2_rdy;
    logic [XLEN-1:0]  v2;
  } entry_t;

  entry_t                      r_ent [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] r_age;
  logic                        r_iss_valid;
  logic [OP_W-1:0]             r_iss_op;
  logic [XLEN-1:0]             r_iss_v1;
  logic [XLEN-1:0]             r_iss_v2;
  logic [TAG_W-1:0]            r_iss_tag;

  logic [DEPTH-1:0]  w_req;
  logic [DEPTH-1:0]  w_gnt;
  logic              w_any;
  logic [IDX_W-1:0]  w_free_idx;
  logic [OCC_W-1:0]  w_occ;
  logic              w_disp;
  logic              w_load;
  entry_t            w_new;
  entry_t            w_sel;
  logic [XLEN:0]     w_byp1;
  logic [XLEN:0]     w_byp2;
  logic [XLEN:0]     w_wk1 [DEPTH];
  logic [XLEN:0]     w_wk2 [DEPTH];

  // Returns {hit, value}; lowest-index matching channel wins.
  function automatic logic [XLEN:0] f_snoop(input logic [TAG_W-1:0] tag);
    logic [XLEN:0] res;
    res = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (!res[XLEN] && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag)
        res = {1'b1, cdb_val[k*XLEN +: XLEN]};
    end
    return res;
  endfunction

  // Per-entry issue eligibility and CDB snoop results
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_req[i] = r_ent[i].valid & r_ent[i].q1_rdy & r_ent[i].q2_rdy;
      w_wk1[i] = f_snoop(r_ent[i].v1[TAG_W-1:0]);
      w_wk2[i] = f_snoop(r_ent[i].v2[TAG_W-1:0]);
    end
  end

  rs_select #(.DEPTH(DEPTH)) u_select (
    .i_req (w_req),
    .i_age (r_age),
    .o_gnt (w_gnt),
    .o_any (w_any)
  );

  // Lowest free slot and occupancy, both from registered valid bits only
  always_comb begin
    w_free_idx = '0;
    w_occ      = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (!r_ent[i-1].valid) w_free_idx = IDX_W'(i-1);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(r_ent[i].valid);
    end
  end

  assign disp_ready = (w_occ < FULL);
  assign w_disp     = rdy & disp_valid & disp_ready & ~flush;
  assign w_load     = rdy & ~flush & w_any & (~r_iss_valid | iss_ready);

  // Dispatched record, with same-cycle CDB bypass on waiting operands
  always_comb begin
    w_byp1       = f_snoop(disp_v1[TAG_W-1:0]);
    w_byp2       = f_snoop(disp_v2[TAG_W-1:0]);
    w_new        = '0;
    w_new.valid  = 1'b1;
    w_new.op     = disp_op;
    w_new.tag    = disp_tag;
    w_new.q1_rdy = disp_q1_rdy | w_byp1[XLEN];
    w_new.v1     = (!disp_q1_rdy && w_byp1[XLEN]) ? w_byp1[XLEN-1:0] : disp_v1;
    w_new.q2_rdy = disp_q2_rdy | w_byp2[XLEN];
    w_new.v2     = (!disp_q2_rdy && w_byp2[XLEN]) ? w_byp2[XLEN-1:0] : disp_v2;
  end

  // One-hot mux of the granted entry
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_gnt[i]) w_sel = w_sel | r_ent[i];
    end
  end

  // Entry array and age matrix: flush, wakeup, free-on-load, dispatch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_age <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
        r_age <= '0;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (r_ent[i].valid && !r_ent[i].q1_rdy && w_wk1[i][XLEN]) begin
            r_ent[i].q1_rdy <= 1'b1;
            r_ent[i].v1     <= w_wk1[i][XLEN-1:0];
          end
          if (r_ent[i].valid && !r_ent[i].q2_rdy && w_wk2[i][XLEN]) begin
            r_ent[i].q2_rdy <= 1'b1;
            r_ent[i].v2     <= w_wk2[i][XLEN-1:0];
          end
          if (w_load && w_gnt[i]) r_ent[i].valid <= 1'b0;
        end
        // New entry is younger than every currently valid entry
        if (w_disp) begin
          r_ent[w_free_idx] <= w_new;
          for (int unsigned j = 0; j < DEPTH; j++) begin
            r_age[w_free_idx][j] <= 1'b0;
            r_age[j][w_free_idx] <= r_ent[j].valid;
          end
        end
      end
    end
  end

  // Issue output register: load when empty or being consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iss_valid <= 1'b0;
      r_iss_op    <= '0;
      r_iss_v1    <= '0;
      r_iss_v2    <= '0;
      r_iss_tag   <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_iss_valid <= 1'b0;
      end else if (w_load) begin
        r_iss_valid <= 1'b1;
        r_iss_op    <= w_sel.op;
        r_iss_v1    <= w_sel.v1;
        r_iss_v2    <= w_sel.v2;
        r_iss_tag   <= w_sel.tag;
      end else if (iss_ready) begin
        r_iss_valid <= 1'b0;
      end
    end
  end

  assign iss_valid = r_iss_valid;
  assign iss_op    = r_iss_op;
  assign iss_v1    = r_iss_v1;
  assign iss_v2    = r_iss_v2;
  assign iss_tag   = r_iss_tag;
  assign occupancy = w_occ;

endmodule
